// File: rtl/paddle_reader.sv
// paddle_reader: synchronizes the two paddle comparator pins, timestamps the
// first rising edge of each pin per frame with the current scanline, and
// publishes the captured values once per frame on the vsync rise.
// Optional build macro: PADDLE_SMOOTH_EN (blend each new capture with the
// previously published value).

module paddle_chan #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_pin,
    input  logic [7:0] i_cap_val,
    input  logic       i_frame,
    output logic [7:0] o_out,
    output logic       o_valid
);
    typedef enum logic {ARMED = 1'b0, HELD = 1'b1} state_t;

    state_t                 r_state;
    state_t                 w_state_nx;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_d;
    logic                   w_edge;
    logic [7:0]             r_cap;
    logic [7:0]             w_cap_nx;
    logic [7:0]             r_out;
    logic [7:0]             w_out_nx;
    logic [7:0]             w_pub;
    logic                   r_valid;
    logic                   w_valid_nx;

    // Pin synchronizer chain plus a delayed copy of its last stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync   <= '0;
            r_sync_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_sync_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_edge = r_sync[SYNC_STAGES-1] & ~r_sync_d;

`ifdef PADDLE_SMOOTH_EN
    // Sum fits in 9 bits (255+255+1); the first capture after an invalid
    // frame is taken as-is so stale data is not blended in.
    logic [8:0] w_sum;
    assign w_sum = {1'b0, r_out} + {1'b0, r_cap} + 9'd1;
    assign w_pub = r_valid ? w_sum[8:1] : r_cap;
`else
    assign w_pub = r_cap;
`endif

    // State, capture and published-value registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ARMED;
            r_cap   <= 8'd0;
            r_out   <= 8'd0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cap   <= w_cap_nx;
            r_out   <= w_out_nx;
            r_valid <= w_valid_nx;
        end
    end

    // Publish on the frame boundary using the old state; an edge in the same
    // cycle belongs to the new frame and re-captures into HELD.
    always_comb begin
        w_state_nx = r_state;
        w_cap_nx   = r_cap;
        w_out_nx   = r_out;
        w_valid_nx = r_valid;
        if (i_frame) begin
            w_valid_nx = (r_state == HELD);
            if (r_state == HELD) w_out_nx = w_pub;
            w_state_nx = ARMED;
        end
        if (w_edge && (i_frame || r_state == ARMED)) begin
            w_state_nx = HELD;
            w_cap_nx   = i_cap_val;
        end
    end

    assign o_out   = r_out;
    assign o_valid = r_valid;
endmodule

module paddle_reader #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hpaddle,
    input  logic       vpaddle,
    input  logic [8:0] vpos,
    input  logic       vsync,
    output logic [7:0] paddle_x,
    output logic [7:0] paddle_y,
    output logic       x_valid,
    output logic       y_valid,
    output logic       frame_strobe
);
    logic            r_vsync_d;
    logic            r_strobe;
    logic            w_frame;
    logic [7:0]      w_vpos_clamp;
    logic [1:0]      w_pins;
    logic [1:0][7:0] w_out;
    logic [1:0]      w_valid;

    // Scanlines past 255 saturate so the 8-bit value stays monotonic.
    assign w_vpos_clamp = vpos[8] ? 8'hFF : vpos[7:0];
    assign w_frame      = vsync & ~r_vsync_d;
    assign w_pins       = {vpaddle, hpaddle};

    // vsync delay resets high so vsync already high at release is not a boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vsync_d <= 1'b1;
            r_strobe  <= 1'b0;
        end else begin
            r_vsync_d <= vsync;
            r_strobe  <= w_frame;
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_chan
        paddle_chan #(.SYNC_STAGES(SYNC_STAGES)) u_chan (
            .clk       (clk),
            .reset     (reset),
            .i_pin     (w_pins[i]),
            .i_cap_val (w_vpos_clamp),
            .i_frame   (w_frame),
            .o_out     (w_out[i]),
            .o_valid   (w_valid[i])
        );
    end

    assign paddle_x     = w_out[0];
    assign paddle_y     = w_out[1];
    assign x_valid      = w_valid[0];
    assign y_valid      = w_valid[1];
    assign frame_strobe = r_strobe;
endmodule

// File: tb/tb_paddle_reader.sv
// tb_paddle_reader: scoreboard bench; stimulus pushes expected per-frame
// results, a monitor pops them on frame_strobe and checks stability between.
module tb_paddle_reader;
    localparam int S = 2;

    logic       clk = 1'b0;
    logic       reset, hpaddle, vpaddle, vsync;
    logic [8:0] vpos;
    logic [7:0] paddle_x, paddle_y;
    logic       x_valid, y_valid, frame_strobe;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int x; int y; int xv; int yv;
    } exp_t;
    exp_t sb[$];

    // reference model state
    int m_out_x, m_out_y, m_val_x, m_val_y, m_cap_x, m_cap_y, m_has_x, m_has_y;
    int px, py;

    paddle_reader #(.SYNC_STAGES(S)) dut (
        .clk(clk), .reset(reset), .hpaddle(hpaddle), .vpaddle(vpaddle),
        .vpos(vpos), .vsync(vsync), .paddle_x(paddle_x), .paddle_y(paddle_y),
        .x_valid(x_valid), .y_valid(y_valid), .frame_strobe(frame_strobe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int clampv(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    function automatic int pubv(input int out, input int cap, input int prev_valid);
`ifdef PADDLE_SMOOTH_EN
        return prev_valid ? (out + cap + 1) / 2 : cap;
`else
        return cap;
`endif
    endfunction

    task automatic note_x(input int vp);
        if (!m_has_x) begin m_has_x = 1; m_cap_x = clampv(vp); end
    endtask
    task automatic note_y(input int vp);
        if (!m_has_y) begin m_has_y = 1; m_cap_y = clampv(vp); end
    endtask

    task automatic publish();
        exp_t e;
        if (m_has_x) begin m_out_x = pubv(m_out_x, m_cap_x, m_val_x); m_val_x = 1; end
        else m_val_x = 0;
        if (m_has_y) begin m_out_y = pubv(m_out_y, m_cap_y, m_val_y); m_val_y = 1; end
        else m_val_y = 0;
        e.x = m_out_x; e.y = m_out_y; e.xv = m_val_x; e.yv = m_val_y;
        sb.push_back(e);
        m_has_x = 0; m_has_y = 0;
    endtask

    // One scanline slot of 8 cycles. Actions: 0 none, 1 pulse, 2 rise-and-hold, 3 fall.
    task automatic do_slot(input int vp, input int xa_in, input int ya_in);
        int xa, ya, xo, yo;
        xa = xa_in; ya = ya_in;
        if (px == 1 && (xa == 1 || xa == 2)) xa = 0;
        if (px == 0 && xa == 3) xa = 0;
        if (py == 1 && (ya == 1 || ya == 2)) ya = 0;
        if (py == 0 && ya == 3) ya = 0;
        xo = $urandom_range(0, 3);
        yo = $urandom_range(0, 3);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) vpos = vp[8:0];
            if ((xa == 1 || xa == 2) && c == xo) begin hpaddle = 1'b1; note_x(vp); end
            if ((xa == 1 && c == 5) || (xa == 3 && c == 2)) hpaddle = 1'b0;
            if ((ya == 1 || ya == 2) && c == yo) begin vpaddle = 1'b1; note_y(vp); end
            if ((ya == 1 && c == 5) || (ya == 3 && c == 2)) vpaddle = 1'b0;
        end
        px = int'(hpaddle); py = int'(vpaddle);
    endtask

    // Guard slot, then vsync rise. simul puts a synchronized hpaddle edge
    // (at scanline svp) in the boundary cycle; keep leaves pins as they are.
    task automatic end_frame(input int simul, input int svp, input int keep);
        @(negedge clk);
        if (!keep) begin hpaddle = 1'b0; vpaddle = 1'b0; px = 0; py = 0; end
        repeat (7) @(negedge clk);
        if (simul) begin
            vpos = svp[8:0];
            hpaddle = 1'b1;
            repeat (S) @(negedge clk);
            vsync = 1'b1;
            publish();
            note_x(svp);
        end else begin
            @(negedge clk);
            vsync = 1'b1;
            publish();
        end
        repeat (3) @(negedge clk);
        vsync = 1'b0;
        if (simul) begin hpaddle = 1'b0; px = 0; end
        repeat (2) @(negedge clk);
    endtask

    task automatic model_reset();
        m_out_x = 0; m_out_y = 0; m_val_x = 0; m_val_y = 0;
        m_cap_x = 0; m_cap_y = 0; m_has_x = 0; m_has_y = 0;
    endtask

    // Monitor: pops on strobe, otherwise checks outputs hold their last value.
    exp_t held;
    int   prev_strobe = 0;
    always @(negedge clk) begin
        if (reset) begin
            chk("rst_strobe", frame_strobe, 0);
            chk("rst_x", paddle_x, 0);
            chk("rst_y", paddle_y, 0);
            chk("rst_xv", x_valid, 0);
            chk("rst_yv", y_valid, 0);
            held = '{0, 0, 0, 0};
            prev_strobe = 0;
        end else begin
            if (frame_strobe) begin
                chk("strobe_width", prev_strobe, 0);
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_strobe: got strobe expected none at %0t", $time);
                end else begin
                    held = sb.pop_front();
                end
            end
            chk("paddle_x", paddle_x, held.x);
            chk("paddle_y", paddle_y, held.y);
            chk("x_valid", x_valid, held.xv);
            chk("y_valid", y_valid, held.yv);
            prev_strobe = int'(frame_strobe);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; hpaddle = 1'b0; vpaddle = 1'b0; vsync = 1'b0; vpos = 9'd0;
        px = 0; py = 0;
        model_reset();
        // vsync rises during reset: no strobe; still high at release: no boundary
        repeat (2) @(negedge clk);
        vsync = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vsync = 1'b0;
        repeat (2) @(negedge clk);

        // basic capture
        do_slot(100, 1, 0);
        end_frame(0, 0, 0);

        // mid-clock reset with a pending capture
        do_slot(77, 1, 1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("async_rst_x", paddle_x, 0);
        chk("async_rst_xv", x_valid, 0);
        chk("async_rst_strobe", frame_strobe, 0);
        model_reset();
        @(negedge clk);
        vsync = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        vsync = 1'b0;
        end_frame(0, 0, 0);

        // first-edge-only, then clamp
        do_slot(40, 0, 1);
        do_slot(90, 0, 1);
        end_frame(0, 0, 0);
        do_slot(300, 0, 1);
        end_frame(0, 0, 0);

        // timeout hold
        do_slot(100, 1, 0);
        end_frame(0, 0, 0);
        do_slot(50, 0, 0);
        end_frame(0, 0, 0);

        // edge coincident with boundary
        do_slot(60, 1, 0);
        end_frame(1, 5, 0);
        end_frame(0, 0, 0);

        // pin held high across a boundary gives no new edge
        do_slot(30, 2, 2);
        end_frame(0, 0, 1);
        do_slot(80, 0, 0);
        end_frame(0, 0, 1);
        do_slot(10, 3, 3);
        end_frame(0, 0, 0);

        // blend sequence after an invalid frame
        end_frame(0, 0, 0);
        do_slot(100, 1, 1);
        end_frame(0, 0, 0);
        do_slot(200, 1, 1);
        end_frame(0, 0, 0);
        do_slot(200, 1, 1);
        end_frame(0, 0, 0);

        // randomized frames
        for (int f = 0; f < 30; f++) begin
            int ns;
            ns = $urandom_range(1, 6);
            for (int s = 0; s < ns; s++) begin
                int xa, ya;
                xa = (px != 0) ? ($urandom_range(0, 1) ? 3 : 0) : $urandom_range(0, 2);
                ya = (py != 0) ? ($urandom_range(0, 1) ? 3 : 0) : $urandom_range(0, 2);
                do_slot($urandom_range(0, 511), xa, ya);
            end
            if ($urandom_range(0, 7) == 0 && px == 0)
                end_frame(1, $urandom_range(0, 511), 0);
            else
                end_frame(0, 0, ($urandom_range(0, 3) == 0) ? 1 : 0);
        end
        end_frame(0, 0, 0);

        repeat (5) @(negedge clk);
        chk("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
